// File: rtl/axi4_pkg.sv
// Shared response codes, FSM state types and the byte-address decoder for the
// AXI4-Lite memory target.
package axi4_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} wr_state_t;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rd_state_t;

  // Returns {idx, err}: err sits in the LSB so callers can truncate the result
  // to exactly the index width they need.
  function automatic logic [32:0] addr_decode(input logic [31:0] addr,
                                              input logic [31:0] base,
                                              input logic [31:0] depth);
    logic [31:0] off;
    logic [31:0] idx;
    logic        err;
    off = addr - base;
    idx = off >> 2'd2;
    err = (addr < base) || (idx >= depth) || (addr[1:0] != 2'b00);
    return {idx, err};
  endfunction

endpackage

// File: rtl/axi4_lite_mem_slave.sv
// Memory-backed AXI4-Lite target: independent write and read FSMs over a
// flop-based word array that is cleared on reset.
module axi4_lite_mem_slave
  import axi4_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wvalid,
  output logic                wready,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic                arvalid,
  output logic                arready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rvalid,
  input  logic                rready
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];

  wr_state_t         wr_state_q;
  logic              awready_q, wready_q, bvalid_q;
  logic [1:0]        bresp_q;
  logic              aw_held_q, w_held_q;
  logic [ADDR_W-1:0] awaddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;

  rd_state_t         rd_state_q;
  logic              arready_q, rvalid_q;
  logic [1:0]        rresp_q;
  logic [DATA_W-1:0] rdata_q;

  logic              aw_hs_s, w_hs_s, ar_hs_s;
  logic              aw_held_d, w_held_d, commit_s;
  logic [ADDR_W-1:0] aw_addr_sel_s;
  logic [DATA_W-1:0] w_data_sel_s;
  logic [STRB_W-1:0] w_strb_sel_s;
  logic [IDX_W:0]    wr_dec_s, rd_dec_s;
  logic              wr_err_s, rd_err_s;
  logic [IDX_W-1:0]  wr_idx_s, rd_idx_s;

  assign aw_hs_s   = awvalid && awready_q;
  assign w_hs_s    = wvalid && wready_q;
  assign ar_hs_s   = arvalid && arready_q;
  assign aw_held_d = aw_held_q || aw_hs_s;
  assign w_held_d  = w_held_q || w_hs_s;
  assign commit_s  = (wr_state_q == W_IDLE) && aw_held_d && w_held_d;

  // A handshake arriving on the commit edge is used directly, bypassing the latch.
  assign aw_addr_sel_s = aw_held_q ? awaddr_q : awaddr;
  assign w_data_sel_s  = w_held_q ? wdata_q : wdata;
  assign w_strb_sel_s  = w_held_q ? wstrb_q : wstrb;

  assign wr_dec_s = (IDX_W+1)'(addr_decode(32'(aw_addr_sel_s), BASE_ADDR, 32'(DEPTH)));
  assign rd_dec_s = (IDX_W+1)'(addr_decode(32'(araddr), BASE_ADDR, 32'(DEPTH)));
  assign wr_err_s = wr_dec_s[0];
  assign wr_idx_s = wr_dec_s[IDX_W:1];
  assign rd_err_s = rd_dec_s[0];
  assign rd_idx_s = rd_dec_s[IDX_W:1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      case (wr_state_q)
        W_IDLE: begin
          if (aw_hs_s) awaddr_q <= awaddr;
          if (w_hs_s) begin
            wdata_q <= wdata;
            wstrb_q <= wstrb;
          end
          if (commit_s) begin
            if (!wr_err_s) begin
              for (int b = 0; b < STRB_W; b++) begin
                if (w_strb_sel_s[b]) mem_q[wr_idx_s][8*b +: 8] <= w_data_sel_s[8*b +: 8];
              end
            end
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b1;
            bresp_q    <= wr_err_s ? RESP_SLVERR : RESP_OKAY;
            wr_state_q <= W_RESP;
          end else begin
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awready_q <= !aw_held_d;
            wready_q  <= !w_held_d;
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid_q   <= 1'b0;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            wr_state_q <= W_IDLE;
          end
        end
        default: begin
          bvalid_q   <= 1'b0;
          wr_state_q <= W_IDLE;
        end
      endcase
    end
  end

  // Reads sample mem_q before any same-edge write lands, so collisions see old data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          if (ar_hs_s) begin
            rdata_q    <= rd_err_s ? '0 : mem_q[rd_idx_s];
            rresp_q    <= rd_err_s ? RESP_SLVERR : RESP_OKAY;
            rvalid_q   <= 1'b1;
            arready_q  <= 1'b0;
            rd_state_q <= R_DATA;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (rready) begin
            rvalid_q   <= 1'b0;
            arready_q  <= 1'b1;
            rd_state_q <= R_IDLE;
          end
        end
        default: begin
          rvalid_q   <= 1'b0;
          rd_state_q <= R_IDLE;
        end
      endcase
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rresp   = rresp_q;
  assign rdata   = rdata_q;

endmodule
